lf_sub_pipe_8: RTL and testbench

- 8-bit two's-complement subtractor, pipelined. Computes diff = A - B - Bin.
- Built on the team's Ladner-Fischer prefix carry network, applied to A + ~B + ~Bin.
- Two register stages with valid/ready handshakes on input and output, so it can sit in a streamed datapath between producers and consumers that apply backpressure.
- Companion to the combinational LF adders: it supplies the subtract direction to the same exactness benches.

---
 rtl/lf_sub_pipe_8.sv | 210 +++++++++++++++++++++
 tb/tb_lf_sub_pipe_8.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lf_sub_pipe_8.sv
// Pipelined 8-bit subtractor diff = A - B - Bin on a Ladner-Fischer prefix carry network; optional compare flags via LF_SUB_CMP_FLAGS_EN.
// Latency: two register stages (prefix levels 1-2 before stage 1, level 3 and sum into the output stage).
// Backpressure: valid/ready on both sides; the output holds while out_ready=0 and in_ready drops once both stages are full.
module lf_sub_pipe_8 #(
    parameter int WIDTH          = 8,
    parameter bit RESET_OUT_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             ovf
`ifdef LF_SUB_CMP_FLAGS_EN
    ,
    output logic             eq,
    output logic             lt_u,
    output logic             lt_s
`endif
);

    // Handshake
    logic adv1;
    logic acc;
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;

    // Stage 0 prefix levels 1-2
    logic [7:0] p0, g0;
    logic [3:0] l1_g, l1_p;
    logic [7:0] l2_g, l2_p;

    // Stage 1 registers: group G/P (index i covers [i:0] for i<4, [i:4] for i>=4)
    logic [7:0] s1_gg_q, s1_gg_d;
    logic [7:0] s1_gp_q, s1_gp_d;
    logic [7:0] s1_p_q, s1_p_d;
    logic       s1_c0_q, s1_c0_d;
    logic       s1_a7_q, s1_a7_d;
    logic       s1_b7_q, s1_b7_d;

    // Stage 1 -> 2 level 3 and sum
    logic [7:0] grp_g, grp_p;
    logic [8:0] carry;
    logic [7:0] diff_n;
    logic       bout_n, ovf_n;

    logic [7:0] diff_q, diff_d;
    logic       bout_q, bout_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        adv1        = ~out_valid_q | out_ready;
        in_ready    = ~s1_valid_q | adv1;
        acc         = in_valid & in_ready;
        s1_valid_d  = acc | (s1_valid_q & ~adv1);
        out_valid_d = adv1 ? s1_valid_q : out_valid_q;
    end

    // Subtraction as A + ~B + ~Bin
    always_comb begin
        p0 = A ^ ~B;
        g0 = A & ~B;
        for (int k = 0; k < 4; k++) begin
            l1_g[k] = g0[2*k+1] | (p0[2*k+1] & g0[2*k]);
            l1_p[k] = p0[2*k+1] & p0[2*k];
        end
        l2_g[0] = g0[0];
        l2_p[0] = p0[0];
        l2_g[1] = l1_g[0];
        l2_p[1] = l1_p[0];
        l2_g[2] = g0[2] | (p0[2] & l1_g[0]);
        l2_p[2] = p0[2] & l1_p[0];
        l2_g[3] = l1_g[1] | (l1_p[1] & l1_g[0]);
        l2_p[3] = l1_p[1] & l1_p[0];
        l2_g[4] = g0[4];
        l2_p[4] = p0[4];
        l2_g[5] = l1_g[2];
        l2_p[5] = l1_p[2];
        l2_g[6] = g0[6] | (p0[6] & l1_g[2]);
        l2_p[6] = p0[6] & l1_p[2];
        l2_g[7] = l1_g[3] | (l1_p[3] & l1_g[2]);
        l2_p[7] = l1_p[3] & l1_p[2];
    end

    always_comb begin
        s1_gg_d = s1_gg_q;
        s1_gp_d = s1_gp_q;
        s1_p_d  = s1_p_q;
        s1_c0_d = s1_c0_q;
        s1_a7_d = s1_a7_q;
        s1_b7_d = s1_b7_q;
        if (acc) begin
            s1_gg_d = l2_g;
            s1_gp_d = l2_p;
            s1_p_d  = p0;
            s1_c0_d = ~Bin;
            s1_a7_d = A[7];
            s1_b7_d = B[7];
        end
    end

    always_comb begin
        grp_g[3:0] = s1_gg_q[3:0];
        grp_p[3:0] = s1_gp_q[3:0];
        for (int i = 4; i < 8; i++) begin
            grp_g[i] = s1_gg_q[i] | (s1_gp_q[i] & s1_gg_q[3]);
            grp_p[i] = s1_gp_q[i] & s1_gp_q[3];
        end
        carry[0] = s1_c0_q;
        for (int i = 0; i < 8; i++) begin
            carry[i+1] = grp_g[i] | (grp_p[i] & s1_c0_q);
        end
        diff_n = s1_p_q ^ carry[7:0];
        bout_n = ~carry[8];
        ovf_n  = (s1_a7_q ^ s1_b7_q) & (diff_n[7] ^ s1_a7_q);
    end

    always_comb begin
        diff_d = diff_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        if (adv1 && s1_valid_q) begin
            diff_d = diff_n;
            bout_d = bout_n;
            ovf_d  = ovf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Stage 1 payload is qualified by s1_valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        s1_gg_q <= s1_gg_d;
        s1_gp_q <= s1_gp_d;
        s1_p_q  <= s1_p_d;
        s1_c0_q <= s1_c0_d;
        s1_a7_q <= s1_a7_d;
        s1_b7_q <= s1_b7_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (RESET_OUT_ZERO) begin
                diff_q <= 8'h00;
                bout_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
        end else begin
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign Bout      = bout_q;
    assign ovf       = ovf_q;

`ifdef LF_SUB_CMP_FLAGS_EN
    logic eq_q, eq_d;
    logic lt_u_q, lt_u_d;
    logic lt_s_q, lt_s_d;

    // Equality only holds for a borrow-free A - B with Bin=0 (s1_c0_q = ~Bin)
    always_comb begin
        eq_d   = eq_q;
        lt_u_d = lt_u_q;
        lt_s_d = lt_s_q;
        if (adv1 && s1_valid_q) begin
            eq_d   = (diff_n == 8'h00) & ~bout_n & s1_c0_q;
            lt_u_d = bout_n;
            lt_s_d = diff_n[7] ^ ovf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (RESET_OUT_ZERO) begin
                eq_q   <= 1'b0;
                lt_u_q <= 1'b0;
                lt_s_q <= 1'b0;
            end
        end else begin
            eq_q   <= eq_d;
            lt_u_q <= lt_u_d;
            lt_s_q <= lt_s_d;
        end
    end

    assign eq   = eq_q;
    assign lt_u = lt_u_q;
    assign lt_s = lt_s_q;
`endif

endmodule

// File: tb/tb_lf_sub_pipe_8.sv
// Bench for lf_sub_pipe_8: constant vector table, hand sequences for latency/backpressure/reset, swept stream with random stalls.
module tb_lf_sub_pipe_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       Bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       Bout;
    logic       ovf;
`ifdef LF_SUB_CMP_FLAGS_EN
    logic       eq, lt_u, lt_s;
`endif

    always #5 clk = ~clk;

    lf_sub_pipe_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .Bout      (Bout),
        .ovf       (ovf)
`ifdef LF_SUB_CMP_FLAGS_EN
        ,
        .eq        (eq),
        .lt_u      (lt_u),
        .lt_s      (lt_s)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       eqf;
        logic       ltu;
        logic       lts;
    } vec_t;

    vec_t send_q[$];
    vec_t sb[$];
    vec_t tbl[8];

    int   n_err = 0;
    int   n_chk = 0;
    bit   rand_rdy = 1'b0;
    int   out_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        vec_t v;
        int   t;
        t     = int'(a) - int'(b) - int'(bin);
        v.a   = a;
        v.b   = b;
        v.bin = bin;
        v.d   = t[7:0];
        v.bo  = (t < 0);
        v.ov  = (a[7] != b[7]) && (v.d[7] != a[7]);
        v.eqf = (v.d == 8'h00) && !v.bo && !bin;
        v.ltu = v.bo;
        v.lts = v.d[7] ^ v.ov;
        return v;
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
`ifdef LF_SUB_CMP_FLAGS_EN
        return {18'd0, v.eqf, v.ltu, v.lts, v.d, v.bo, v.ov};
`else
        return {21'd0, 1'b0, 1'b0, 1'b0, v.d, v.bo, v.ov};
`endif
    endfunction

    function automatic logic [31:0] pack_act();
`ifdef LF_SUB_CMP_FLAGS_EN
        return {18'd0, eq, lt_u, lt_s, diff, Bout, ovf};
`else
        return {21'd0, 1'b0, 1'b0, 1'b0, diff, Bout, ovf};
`endif
    endfunction

    // One clock: drive, evaluate handshakes before the edge, check output hold after it
    task automatic step();
        bit          in_fire, out_fire, hold;
        logic [31:0] held;
        in_valid = (send_q.size() > 0);
        if (send_q.size() > 0) begin
            A   = send_q[0].a;
            B   = send_q[0].b;
            Bin = send_q[0].bin;
        end
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        in_fire  = in_valid && in_ready && !rst;
        out_fire = out_valid && out_ready && !rst;
        hold     = out_valid && !out_ready && !rst;
        held     = pack_act();
        if (out_valid && !rst) out_seen++;
        if (out_fire) begin
            if (sb.size() == 0) begin
                check("spurious_output", 32'd1, 32'd0);
            end else begin
                check("result", pack_act(), pack_exp(sb[0]));
                void'(sb.pop_front());
            end
        end
        if (in_fire) begin
            sb.push_back(send_q[0]);
            void'(send_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (hold && !rst) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", pack_act(), held);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((send_q.size() > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", send_q.size() + sb.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] bsel[16];
        int         n;
        bit         seen;

        tbl[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h33, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_outputs", pack_act(), 32'd0);

        // Single op latency: not valid after the accept edge, valid within the next two
        out_ready = 1'b1;
        send_q.push_back(tbl[0]);
        step();
        check("lat_accepted", send_q.size(), 32'd0);
        check("lat_not_early", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else step();
        end
        if (out_valid) seen = 1'b1;
        check("lat_arrived", {31'd0, seen}, 32'd1);
        drain(20);

        // Constant table
        for (int i = 1; i < 8; i++) send_q.push_back(tbl[i]);
        drain(40);

        // Backpressure: 4 back-to-back, stall 3 cycles once the first result shows
        for (int i = 0; i < 4; i++) send_q.push_back(tbl[i]);
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_in_flight", sb.size(), 32'd2);
        out_ready = 1'b1;
        drain(40);

        // Reset mid-flight with outputs stalled; an op offered during rst must be dropped
        out_ready = 1'b0;
        send_q.push_back(tbl[3]);
        send_q.push_back(tbl[4]);
        step();
        step();
        check("mid_two_in", sb.size(), 32'd2);
        send_q.push_back(tbl[5]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        send_q.delete();
        sb.delete();
        check("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        out_seen  = 0;
        for (int i = 0; i < 6; i++) step();
        check("mid_no_stale", out_seen, 32'd0);

        // Swept stream: every A against boundary B values, both Bin, random stalls
        bsel = '{8'h00, 8'h01, 8'h02, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hFE,
                 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h40};
        rand_rdy = 1'b1;
        for (int bi = 0; bi < 2; bi++) begin
            for (int a = 0; a < 256; a++) begin
                for (int j = 0; j < 16; j++) begin
                    send_q.push_back(model(a[7:0], bsel[j], bi[0]));
                end
            end
        end
        for (int i = 0; i < 3000; i++) begin
            send_q.push_back(model($urandom_range(0, 255), $urandom_range(0, 255),
                                   $urandom_range(0, 1)));
        end
        drain(40000);
        rand_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
